// File: rtl/crc_pkg.sv
// Shared types and the single-bit reflected CRC step
// for the parallel CRC engine.
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      OUT
   } state_e;

   // Operates on a 32-bit container; narrower CRCs keep upper bits zero.
   function automatic logic [31:0] crc_bit_step(
      input logic [31:0] crc,
      input logic        d,
      input logic [31:0] poly
   );
      logic fb;
      fb = crc[0] ^ d;
      return (crc >> 1) ^ ({32{fb}} & poly);
   endfunction

endpackage

// File: rtl/crc_unroll.sv
// Combinational DW-fold unrolled reflected CRC update,
// data bit 0 is folded in first.
module crc_unroll
   import crc_pkg::*;
#(
   parameter int unsigned         CRC_W = 8,
   parameter int unsigned         DW    = 8,
   parameter logic [CRC_W-1:0]    POLY  = 'h8C
) (
   input  logic [CRC_W-1:0] crc_in,
   input  logic [DW-1:0]    data,
   output logic [CRC_W-1:0] crc_out
);

   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < DW; i++) begin
         crc_out = CRC_W'(crc_bit_step(32'(crc_out), data[i],
                                       32'(POLY)));
      end
   end

endmodule

// File: rtl/crc_par_engine.sv
// Parametrised reflected CRC generator/checker with parallel
// and LSB-first serial result and a residue-based check flag.
module crc_par_engine
   import crc_pkg::*;
#(
   parameter int unsigned      CRC_W   = 8,
   parameter int unsigned      DW      = 8,
   parameter logic [CRC_W-1:0] POLY    = 'h8C,
   parameter logic [CRC_W-1:0] SEED    = '0,
   parameter logic [CRC_W-1:0] XOROUT  = '0,
   parameter logic [CRC_W-1:0] RESIDUE = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ACTIVE,
   input  logic [DW-1:0]    DATA,
   input  logic             CHECK,
   output logic             Valid,
   output logic             CRC,
   output logic [CRC_W-1:0] CRC_PAR,
   output logic             CRC_OK,
   output logic             BUSY
);

   localparam int CW = $clog2(CRC_W);

   state_e           state_q, state_d;
   logic [CRC_W-1:0] crc_q, crc_d;
   logic [CRC_W-1:0] sh_q, sh_d;
   logic [CRC_W-1:0] par_q, par_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ok_q, ok_d;
   logic             chk_unused_q, chk_unused_d;
   logic [CRC_W-1:0] crc_base;
   logic [CRC_W-1:0] crc_nxt;

   // A frame always starts from SEED, whatever the register holds.
   assign crc_base = (state_q == IDLE) ? SEED : crc_q;

   crc_unroll #(
      .CRC_W (CRC_W),
      .DW    (DW),
      .POLY  (POLY)
   ) u_unroll (
      .crc_in  (crc_base),
      .data    (DATA),
      .crc_out (crc_nxt)
   );

   always_comb begin
      state_d      = state_q;
      crc_d        = crc_q;
      sh_d         = sh_q;
      par_d        = par_q;
      cnt_d        = cnt_q;
      ok_d         = ok_q;
      chk_unused_d = chk_unused_q;
      unique case (state_q)
         IDLE: begin
            if (ACTIVE) begin
               crc_d        = crc_nxt;
               chk_unused_d = CHECK;
               state_d      = CALC;
            end
         end
         CALC: begin
            if (ACTIVE) begin
               crc_d = crc_nxt;
            end else begin
               sh_d    = crc_q ^ XOROUT;
               par_d   = crc_q ^ XOROUT;
               ok_d    = (crc_q == RESIDUE);
               cnt_d   = '0;
               state_d = OUT;
            end
         end
         OUT: begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(CRC_W - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         crc_q        <= SEED;
         sh_q         <= '0;
         par_q        <= '0;
         cnt_q        <= '0;
         ok_q         <= 1'b0;
         chk_unused_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         crc_q        <= crc_d;
         sh_q         <= sh_d;
         par_q        <= par_d;
         cnt_q        <= cnt_d;
         ok_q         <= ok_d;
         chk_unused_q <= chk_unused_d;
      end
   end

   assign Valid   = (state_q == OUT);
   assign BUSY    = (state_q == OUT);
   assign CRC     = Valid & sh_q[0];
   assign CRC_PAR = par_q;
   assign CRC_OK  = ok_q;

endmodule
